// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Loads ALU operand A, operand B and the op select one after another from a
// shared bus. Each value is taken on a synchronised strobe edge. The block
// then waits a fixed number of cycles and holds the captured ALU result.

module alu_operand_sequencer #(
   parameter int DATA_W      = 8,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int EXEC_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] din,
   input  logic              strobe_in,
   input  logic              clear_in,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_s,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] result_out,
   output logic              done,
   output logic [2:0]        state_out
);

   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   strobe_q;
   logic                   load_pulse;
   logic                   exec_last;
   logic [CNT_W-1:0]       exec_cnt;

   logic                   load_a;
   logic                   load_b;
   logic                   load_s;
   logic                   capture;

   // Strobe synchroniser and edge history; runs regardless of ena so that
   // an edge seen while disabled is consumed and cannot fire later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], strobe_in};
         strobe_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign load_pulse = sync_q[SYNC_STAGES-1] & ~strobe_q;
   assign exec_last  = (exec_cnt == CNT_LAST);

   // FSM state register; frozen while the block is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_A;
      end else if (ena) begin
         state <= next_state;
      end
   end

   // Next-state selection; an abort overrides any load in the same cycle.
   always_comb begin
      next_state = state;
      if (clear_in) begin
         next_state = WAIT_A;
      end else begin
         case (state)
            WAIT_A:  if (load_pulse) next_state = WAIT_B;
            WAIT_B:  if (load_pulse) next_state = WAIT_OP;
            WAIT_OP: if (load_pulse) next_state = EXEC;
            EXEC:    if (exec_last)  next_state = SHOW;
            SHOW:    if (load_pulse) next_state = WAIT_B;
            default: next_state = WAIT_A;
         endcase
      end
   end

   // Datapath enables decoded from the current state, qualified by ena and abort.
   always_comb begin
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_s    = 1'b0;
      capture   = 1'b0;
      state_out = state;
      if (ena && !clear_in) begin
         case (state)
            WAIT_A:  load_a  = load_pulse;
            WAIT_B:  load_b  = load_pulse;
            WAIT_OP: load_s  = load_pulse;
            EXEC:    capture = exec_last;
            SHOW:    load_a  = load_pulse;
            default: ;
         endcase
      end
   end

   // Operand and op-select registers; each changes only on its own load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a <= '0;
         alu_b <= '0;
         alu_s <= '0;
      end else begin
         if (load_a) alu_a <= din;
         if (load_b) alu_b <= din;
         if (load_s) alu_s <= din[SEL_W-1:0];
      end
   end

   // Execution counter, captured result and done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_cnt   <= '0;
         result_out <= '0;
         done       <= 1'b0;
      end else if (ena) begin
         if (clear_in) begin
            exec_cnt   <= '0;
            result_out <= '0;
            done       <= 1'b0;
         end else begin
            if (load_s) begin
               exec_cnt <= '0;
            end else if (state == EXEC && !exec_last) begin
               exec_cnt <= exec_cnt + CNT_W'(1);
            end
            if (capture) begin
               result_out <= alu_result;
               done       <= 1'b1;
            end else if (load_a) begin
               done       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: strobe-driven transactions against a
// behavioural model, with results checked by a scoreboard monitor.

module tb_alu_operand_sequencer;

   localparam int DATA_W      = 8;
   localparam int SEL_W       = 2;
   localparam int SYNC_STAGES = 2;
   localparam int EXEC_CYCLES = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ena = 1'b1;
   logic [DATA_W-1:0] din = '0;
   logic              strobe_in = 1'b0;
   logic              clear_in = 1'b0;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [SEL_W-1:0]  alu_s;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] result_out;
   logic              done;
   logic [2:0]        state_out;

   int checks = 0;
   int errors = 0;

   int                exp_state = 0;
   logic [DATA_W-1:0] exp_a = '0;
   logic [DATA_W-1:0] exp_b = '0;
   logic [SEL_W-1:0]  exp_s = '0;
   logic [DATA_W-1:0] exp_q[$];
   logic              done_prev = 1'b0;

   alu_operand_sequencer #(
      .DATA_W(DATA_W), .SEL_W(SEL_W),
      .SYNC_STAGES(SYNC_STAGES), .EXEC_CYCLES(EXEC_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
      .strobe_in(strobe_in), .clear_in(clear_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_result(alu_result), .result_out(result_out),
      .done(done), .state_out(state_out)
   );

   // ALU stub: add for select 0, subtract otherwise.
   assign alu_result = (alu_s == '0) ? alu_a + alu_b : alu_a - alu_b;

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model of one accepted load; returns 1 when the op select was taken.
   task automatic modelLoad(input logic [DATA_W-1:0] v, output bit is_op);
      logic [DATA_W-1:0] r;
      is_op = 1'b0;
      case (exp_state)
         0, 4: begin exp_a = v; exp_state = 1; end
         1:    begin exp_b = v; exp_state = 2; end
         2: begin
            exp_s = v[SEL_W-1:0];
            r = (exp_s == 0) ? exp_a + exp_b : exp_a - exp_b;
            exp_q.push_back(r);
            exp_state = 3;
            is_op = 1'b1;
         end
         default: exp_state = 0;
      endcase
   endtask

   // One full strobe pulse; checks exact load latency and the loaded registers.
   task automatic applyStimulus(input logic [DATA_W-1:0] v, input bit expect_load);
      int pre_state;
      bit is_op;
      pre_state = exp_state;
      @(negedge clk);
      din = v;
      strobe_in = 1'b1;
      repeat (SYNC_STAGES) @(negedge clk);
      checkOutput("state_before_load", state_out, pre_state);
      @(negedge clk);
      is_op = 1'b0;
      if (expect_load) modelLoad(v, is_op);
      checkOutput("state_after_load", state_out, exp_state);
      checkOutput("alu_a", alu_a, exp_a);
      checkOutput("alu_b", alu_b, exp_b);
      checkOutput("alu_s", alu_s, exp_s);
      if (is_op) begin
         repeat (EXEC_CYCLES) @(negedge clk);
         exp_state = 4;
         checkOutput("done_after_exec", done, 1);
         checkOutput("state_show", state_out, 4);
      end else begin
         checkOutput("done", done, (exp_state == 4) ? 1 : 0);
         @(negedge clk);
      end
      strobe_in = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clk);
   endtask

   task automatic runTransaction(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic [DATA_W-1:0] s);
      applyStimulus(a, 1'b1);
      applyStimulus(b, 1'b1);
      applyStimulus(s, 1'b1);
   endtask

   // Scoreboard monitor: every rising done must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done && !done_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: result 0x%0h with no expected entry", result_out);
         end else begin
            checkOutput("result_out", result_out, exp_q.pop_front());
         end
      end
      done_prev = done;
   end

   initial begin
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_alu_a", alu_a, 0);
      checkOutput("reset_alu_b", alu_b, 0);
      checkOutput("reset_alu_s", alu_s, 0);
      checkOutput("reset_result", result_out, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_state", state_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      runTransaction(8'h12, 8'h34, 8'h00);
      runTransaction(8'hF0, 8'h20, 8'h01);
      runTransaction(8'hFF, 8'h02, 8'h00);

      // Long strobe gives a single load.
      @(negedge clk);
      din = 8'h55;
      strobe_in = 1'b1;
      repeat (20) @(negedge clk);
      strobe_in = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clk);
      exp_a = 8'h55;
      exp_state = 1;
      checkOutput("held_strobe_state", state_out, 1);
      checkOutput("held_strobe_alu_a", alu_a, 8'h55);
      checkOutput("held_strobe_done", done, 0);

      // Abort coinciding with a load edge.
      applyStimulus(8'h66, 1'b1);
      @(negedge clk);
      din = 8'h03;
      strobe_in = 1'b1;
      repeat (SYNC_STAGES) @(negedge clk);
      clear_in = 1'b1;
      @(negedge clk);
      clear_in = 1'b0;
      exp_state = 0;
      checkOutput("clear_state", state_out, 0);
      checkOutput("clear_done", done, 0);
      checkOutput("clear_result", result_out, 0);
      checkOutput("clear_alu_s", alu_s, exp_s);
      checkOutput("clear_alu_b", alu_b, exp_b);
      strobe_in = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clk);

      // Strobes while disabled are discarded.
      ena = 1'b0;
      applyStimulus(8'hA1, 1'b0);
      applyStimulus(8'hA2, 1'b0);
      applyStimulus(8'hA3, 1'b0);
      ena = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("ena_state", state_out, 0);
      applyStimulus(8'h99, 1'b1);
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h02, 1'b1);

      // Randomised transactions.
      for (int i = 0; i < 20; i++) begin
         runTransaction(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
      end

      // Asynchronous reset during EXEC.
      applyStimulus(8'h21, 1'b1);
      applyStimulus(8'h43, 1'b1);
      @(negedge clk);
      din = 8'h00;
      strobe_in = 1'b1;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      checkOutput("mid_exec_state", state_out, 3);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_alu_a", alu_a, 0);
      checkOutput("async_rst_alu_b", alu_b, 0);
      checkOutput("async_rst_result", result_out, 0);
      checkOutput("async_rst_done", done, 0);
      checkOutput("async_rst_state", state_out, 0);
      strobe_in = 1'b0;
      exp_state = 0;
      exp_a = '0;
      exp_b = '0;
      exp_s = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // New transaction started from SHOW.
      runTransaction(8'h05, 8'h03, 8'h01);
      applyStimulus(8'h07, 1'b1);
      checkOutput("show_restart_state", state_out, 1);
      checkOutput("show_restart_alu_a", alu_a, 8'h07);

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
